// File: rtl/hc165_pkg.sv
// Shared constants and FSM encoding for the 74HC165 cascade reader.
package hc165_pkg;

    localparam int DIV_DEF    = 3;
    localparam int N_BITS_DEF = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/hc165_clkgen.sv
// Shift-clock divider: free-runs only while enabled and rests at zero otherwise,
// so cp always starts a transfer in its low half.
module hc165_clkgen
    import hc165_pkg::*;
#(
    parameter int DIV = DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic cp,
    output logic sample,
    output logic wrap
);

    localparam logic [DIV-1:0] SAMPLE_AT = DIV'((2 ** (DIV - 1)) - 1);

    logic [DIV-1:0] cnt_div_q, cnt_div_d;

    always_comb begin
        cnt_div_d = '0;
        if (en) cnt_div_d = cnt_div_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_div_q <= '0;
        else        cnt_div_q <= cnt_div_d;
    end

    // Sample on the last low-half cycle, just before the chips shift on cp rising.
    assign cp     = cnt_div_q[DIV-1];
    assign sample = en && (cnt_div_q == SAMPLE_AT);
    assign wrap   = en && (&cnt_div_q);

endmodule

// File: rtl/hc165_reader.sv
// Reads an N_BITS word from cascaded 74HC165 shift registers, MSB first,
// and presents it on dout with a one-cycle dout_vld strobe.
module hc165_reader
    import hc165_pkg::*;
#(
    parameter int DIV    = DIV_DEF,
    parameter int N_BITS = N_BITS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic              q7,
    output logic              pl_n,
    output logic              cp,
    output logic [N_BITS-1:0] dout,
    output logic              dout_vld,
    output logic              busy
);

    localparam int                BW        = $clog2(N_BITS);
    localparam logic [BW-1:0]     BIT_LAST  = BW'(N_BITS - 1);
    localparam logic [DIV-2:0]    LOAD_LAST = (DIV - 1)'((2 ** (DIV - 1)) - 1);

    state_t              state_q, state_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DIV-2:0]      load_cnt_q, load_cnt_d;
    logic [N_BITS-1:0]   cap_q, cap_d;
    logic [N_BITS-1:0]   dout_q, dout_d;
    logic                dout_vld_q, dout_vld_d;
    logic                pl_n_q, pl_n_d;
    logic                busy_q, busy_d;
    logic                q7_q;
    logic                shift_en, sample, wrap;

    assign shift_en = (state_q == ST_SHIFT);

    hc165_clkgen #(.DIV(DIV)) u_clkgen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (shift_en),
        .cp     (cp),
        .sample (sample),
        .wrap   (wrap)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        load_cnt_d = load_cnt_q;
        cap_d      = cap_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        pl_n_d     = pl_n_q;
        busy_d     = busy_q;
        case (state_q)
            ST_IDLE: begin
                pl_n_d = 1'b1;
                busy_d = 1'b0;
                if (rd_req) begin
                    state_d    = ST_LOAD;
                    pl_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    load_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            ST_LOAD: begin
                load_cnt_d = load_cnt_q + 1'b1;
                if (load_cnt_q == LOAD_LAST) begin
                    state_d = ST_SHIFT;
                    pl_n_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (sample) cap_d = {cap_q[N_BITS-2:0], q7_q};
                if (wrap) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    // Last sample was taken mid-period, so cap_q is already complete.
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d    = ST_DONE;
                        dout_d     = cap_q;
                        dout_vld_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                pl_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            load_cnt_q <= '0;
            cap_q      <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            pl_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            q7_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            load_cnt_q <= load_cnt_d;
            cap_q      <= cap_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            pl_n_q     <= pl_n_d;
            busy_q     <= busy_d;
            q7_q       <= q7;
        end
    end

    assign pl_n     = pl_n_q;
    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_hc165_reader.sv
// Scoreboard bench for hc165_reader driven by a behavioural 74HC165 cascade.
module tb_hc165_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_req = 1'b0;
    logic        q7;
    logic        pl_n, cp, dout_vld, busy;
    logic [15:0] dout;

    logic [15:0] par = 16'h0000;
    logic [15:0] sr  = 16'h0000;

    typedef struct {
        logic [15:0] data;
        int          at;
    } exp_t;
    exp_t exp_q[$];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int vld_cnt = 0;
    int cp_rise = 0;
    int pl_low = 0;
    int s;

    hc165_reader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_req   (rd_req),
        .q7       (q7),
        .pl_n     (pl_n),
        .cp       (cp),
        .dout     (dout),
        .dout_vld (dout_vld),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Cascade model: async parallel load while pl_n low, shift on cp rising.
    always @(posedge cp or negedge pl_n) begin
        if (!pl_n) sr <= par;
        else       sr <= {sr[14:0], 1'b0};
    end
    assign q7 = sr[15];

    always @(posedge cp) cp_rise++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every dout_vld.
    logic prev_vld = 1'b0;
    always @(negedge clk) begin
        if (!pl_n) pl_low++;
        if (dout_vld) begin
            vld_cnt++;
            if (prev_vld) chk("vld_width", 32'd2, 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_vld", {16'h0, dout}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("dout", {16'h0, dout}, {16'h0, e.data});
                chk("vld_edge", cyc, e.at);
            end
        end
        prev_vld = dout_vld;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic start_read(input logic [15:0] pat, input bit push, output int st);
        exp_t e;
        par = pat;
        tick();
        rd_req = 1'b1;
        st = cyc + 1;
        if (push) begin
            e.data = pat;
            e.at   = st + 132;
            exp_q.push_back(e);
        end
        tick();
        rd_req = 1'b0;
        chk("busy_start", {31'h0, busy}, 32'd1);
    endtask

    task automatic wait_idle(input int st);
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            tick();
        end
        chk("idle_edge", cyc, st + 133);
    endtask

    logic [15:0] pats[4] = '{16'h8000, 16'h0001, 16'hFFFF, 16'h0000};

    initial begin
        repeat (3) tick();
        chk("rst_pl_n", {31'h0, pl_n}, 32'd1);
        chk("rst_cp", {31'h0, cp}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_dout", {16'h0, dout}, 32'd0);
        chk("rst_vld", {31'h0, dout_vld}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic read with pulse-shape checks
        cp_rise = 0;
        pl_low = 0;
        start_read(16'hA5C3, 1'b1, s);
        wait_idle(s);
        chk("pl_low_cycles", pl_low, 4);
        chk("cp_rises", cp_rise, 16);

        // Bit-order patterns
        foreach (pats[i]) begin
            start_read(pats[i], 1'b1, s);
            wait_idle(s);
        end

        // Second request mid-transfer is dropped
        start_read(16'h3C5A, 1'b1, s);
        run_to(s + 49);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("busy_mid", {31'h0, busy}, 32'd1);
        wait_idle(s);
        repeat (5) tick();
        chk("no_queued_req", {31'h0, busy}, 32'd0);

        // rd_req held: two back-to-back transfers
        begin
            exp_t e;
            par = 16'h1234;
            tick();
            rd_req = 1'b1;
            s = cyc + 1;
            e.data = 16'h1234; e.at = s + 132; exp_q.push_back(e);
            e.data = 16'hBEEF; e.at = s + 266; exp_q.push_back(e);
            run_to(s + 10);
            par = 16'hBEEF;
            run_to(s + 133);
            chk("b2b_gap_idle", {31'h0, busy}, 32'd0);
            run_to(s + 266);
            rd_req = 1'b0;
            run_to(s + 268);
            chk("b2b_end_idle", {31'h0, busy}, 32'd0);
        end

        // Reset mid-shift aborts the transfer
        start_read(16'h7E81, 1'b0, s);
        run_to(s + 69);
        rst_n = 1'b0;
        tick();
        chk("abort_pl_n", {31'h0, pl_n}, 32'd1);
        chk("abort_cp", {31'h0, cp}, 32'd0);
        chk("abort_busy", {31'h0, busy}, 32'd0);
        chk("abort_dout", {16'h0, dout}, 32'd0);
        chk("abort_vld", {31'h0, dout_vld}, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (150) tick();
        chk("abort_idle", {31'h0, busy}, 32'd0);
        start_read(16'h00FF, 1'b1, s);
        wait_idle(s);

        // Parallel inputs change after load; captured value must be the loaded one
        start_read(16'h5555, 1'b1, s);
        run_to(s + 10);
        par = 16'hAAAA;
        wait_idle(s);
        repeat (5) tick();
        chk("dout_hold", {16'h0, dout}, 32'h5555);

        chk("sb_empty", exp_q.size(), 0);
        chk("vld_count", vld_cnt, 10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hc165_reader.md
HC165_READER -- requirements
Module: hc165_reader

Interface
REQ-001 SHALL have parameter DIV, default 3, log2 of clk cycles per shift-clock period (period 2^DIV, DIV >= 2).
REQ-002 SHALL have parameter N_BITS, default 16, bits per read (two cascaded 74HC165).
REQ-003 SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rd_req  input  1  start-read request, sampled only in IDLE.
REQ-006 SHALL have port q7  input  1  serial data from last chip in cascade, MSB first.
REQ-007 SHALL have port pl_n  output  1  parallel-load strobe to chips, active low.
REQ-008 SHALL have port cp  output  1  shift clock to chips; chips shift on rising edge.
REQ-009 SHALL have port dout  output  N_BITS  captured parallel word.
REQ-010 SHALL have port dout_vld  output  1  one-cycle strobe, dout valid.
REQ-011 SHALL have port busy  output  1  transfer in progress.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE; all outputs registered.
REQ-013 IDLE: pl_n=1, cp=0, busy=0; rd_req=1 at a clk edge moves to LOAD with busy=1.
REQ-014 LOAD: pl_n=0, cp=0 for HALF=2^(DIV-1) cycles, then SHIFT with pl_n=1.
REQ-015 SHIFT: DIV-bit divider counter cnt_div 0..2^DIV-1; cp = cnt_div[DIV-1], so low half then high half.
REQ-016 SHIFT: q7 SHALL pass through one input flop; the flopped value SHALL be shifted into the LSB of the capture register (shift left) when cnt_div == HALF-1.
REQ-017 A bit counter SHALL increment when cnt_div wraps; exactly N_BITS cp rising edges and N_BITS samples per transfer.
REQ-018 When the bit counter is N_BITS-1 and cnt_div wraps, SHALL enter DONE with cp=0; the first sampled bit SHALL be dout[N_BITS-1].
REQ-019 DONE lasts one cycle: dout = capture register, dout_vld=1, busy=1; next state IDLE.
REQ-020 Latency: dout_vld SHALL rise at clk edge HALF + N_BITS*2^DIV after the edge sampling rd_req (132 for defaults).
REQ-021 rd_req SHALL be ignored in LOAD, SHIFT and DONE, with no queuing.
REQ-022 rd_req held high SHALL give back-to-back transfers, each separated by exactly one IDLE cycle.
REQ-023 dout SHALL hold its value between DONE cycles.
REQ-024 Bit counter width SHALL be clog2(N_BITS); cnt_div wrap SHALL be modulo 2^DIV, with no saturation.

Reset
REQ-025 rst_n=0 at a clk edge SHALL force IDLE, pl_n=1, cp=0, busy=0, dout=0, dout_vld=0, counters 0, capture register 0.
REQ-026 Reset during LOAD or SHIFT SHALL abort the transfer, with no dout_vld; the next rd_req after release SHALL start a clean transfer.
REQ-027 Reset SHALL take priority over rd_req in the same cycle.

Structure
REQ-028 Package hc165_pkg SHALL hold the FSM state typedef and default constants (DIV_DEF=3, N_BITS_DEF=16).
REQ-029 Sub-module hc165_clkgen SHALL hold cnt_div, cp generation, the sample strobe and the wrap strobe; it SHALL be enabled only in SHIFT.
REQ-030 The FSM, bit counter and capture register SHALL live in hc165_reader.

Verification
REQ-031 Reset, 1-cycle rd_req, chip model holding 16'hA5C3 -> pl_n low 4 cycles, 16 cp rising edges, dout=16'hA5C3, dout_vld high exactly 1 cycle at edge 132.
REQ-032 Patterns 16'h8000, 16'h0001, 16'hFFFF, 16'h0000 -> dout equals pattern, confirming MSB-first order.
REQ-033 rd_req pulses at cycles 0 and 50 -> one transfer, one dout_vld; busy high from edge 0 through edge 132.
REQ-034 rd_req held high 300 cycles, model 16'h1234 then 16'hBEEF -> two transfers, dout_vld at edges 132 and 266, values in order.
REQ-035 rst_n low at cycle 70 for 2 cycles -> next edge pl_n=1, cp=0, busy=0, dout=0, no dout_vld; following read of 16'h00FF gives dout=16'h00FF.
REQ-036 Model parallel inputs changed from 16'h5555 to 16'hAAAA after pl_n rises -> dout=16'h5555.
